// File: rtl/lfsr_timer_pkg.sv
// rtl/lfsr_timer_pkg.sv - shared state type, default constants and maximal-length tap table
package lfsr_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TAPS_DEFAULT8 = 8'b1000_1110;
  localparam logic [7:0] TERM_DEFAULT8 = 8'hE1;

  // Mask bit k feeds bit k of the register into the new bit0.
  function automatic logic [31:0] max_taps(input int width);
    case (width)
      3:       max_taps = 32'h0000_0006;
      4:       max_taps = 32'h0000_000C;
      5:       max_taps = 32'h0000_0014;
      6:       max_taps = 32'h0000_0030;
      7:       max_taps = 32'h0000_0060;
      8:       max_taps = 32'h0000_00B8;
      9:       max_taps = 32'h0000_0110;
      10:      max_taps = 32'h0000_0240;
      11:      max_taps = 32'h0000_0500;
      12:      max_taps = 32'h0000_0829;
      13:      max_taps = 32'h0000_100D;
      14:      max_taps = 32'h0000_2015;
      15:      max_taps = 32'h0000_6000;
      16:      max_taps = 32'h0000_D008;
      17:      max_taps = 32'h0001_2000;
      18:      max_taps = 32'h0002_0400;
      19:      max_taps = 32'h0004_0023;
      20:      max_taps = 32'h0009_0000;
      21:      max_taps = 32'h0014_0000;
      22:      max_taps = 32'h0030_0000;
      23:      max_taps = 32'h0042_0000;
      24:      max_taps = 32'h00E1_0000;
      25:      max_taps = 32'h0120_0000;
      26:      max_taps = 32'h0200_0023;
      27:      max_taps = 32'h0400_0013;
      28:      max_taps = 32'h0900_0000;
      29:      max_taps = 32'h1400_0000;
      30:      max_taps = 32'h2000_0029;
      31:      max_taps = 32'h4800_0000;
      32:      max_taps = 32'h8020_0003;
      default: max_taps = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR register with reload/step controls, lockup guard and terminal compare
module lfsr_core
  import lfsr_timer_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT8),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_reload,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_match
);

  logic [WIDTH-1:0] r_lfsr;
  logic             w_fb;

  assign w_fb    = ^(r_lfsr & TAPS);
  assign o_match = (r_lfsr == i_term);

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (i_reload) begin
      r_lfsr <= SEED;
    end else if (i_step) begin
      // All-zero is a dead state for an XOR LFSR; recover to SEED silently.
      if (r_lfsr == '0) r_lfsr <= SEED;
      else              r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/lfsr_timer_prog.sv
// rtl/lfsr_timer_prog.sv - programmable LFSR tick timer; LFSR_TIMER_PULSE_CNT_EN adds pulse_cnt
module lfsr_timer_prog
  import lfsr_timer_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_DEFAULT8),
  parameter logic [WIDTH-1:0] SEED         = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TERM_DEFAULT = WIDTH'(TERM_DEFAULT8)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             oneshot,
  input  logic             term_load,
  input  logic [WIDTH-1:0] term_value,
`ifdef LFSR_TIMER_PULSE_CNT_EN
  output logic [15:0]      pulse_cnt,
`endif
  output logic             pulseOut,
  output logic             done,
  output logic             running
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_term;
  logic             r_pulse;
  logic             w_match;
  logic             w_fire;
  logic             w_step;
  logic             w_reload;

  assign w_fire   = enable && !term_load && (r_state == RUN) && w_match;
  assign w_step   = enable && !term_load &&
                    ((r_state == IDLE) || ((r_state == RUN) && !w_match));
  // Every edge that does not advance the sequence parks it at SEED.
  assign w_reload = !w_step;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock    (clock),
    .rst      (rst),
    .i_reload (w_reload),
    .i_step   (w_step),
    .i_term   (r_term),
    .o_match  (w_match)
  );

  always_ff @(posedge clock) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (term_load) begin
      w_next = enable ? RUN : IDLE;
    end else if (!enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = RUN;
        RUN:     if (w_match && oneshot) w_next = DONE;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    case (r_state)
      RUN:     running = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  assign pulseOut = r_pulse;

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_term  <= TERM_DEFAULT;
      r_pulse <= 1'b0;
    end else begin
      if (term_load && (term_value != '0)) r_term <= term_value;
      r_pulse <= w_fire;
    end
  end

`ifdef LFSR_TIMER_PULSE_CNT_EN
  logic [15:0] r_pulse_cnt;

  always_ff @(posedge clock) begin
    if (!rst || term_load)                        r_pulse_cnt <= '0;
    else if (w_fire && (r_pulse_cnt != 16'hFFFF)) r_pulse_cnt <= r_pulse_cnt + 16'd1;
  end

  assign pulse_cnt = r_pulse_cnt;
`endif

endmodule
